// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source side of a toggle-encoded request/acknowledge
// handshake carrying one WIDTH-bit word per transfer across clock domains.
module cdc_hs_tx #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    input  logic             err_clr,
    output logic             timeout_err,
    output logic             proto_err,
    output logic [15:0]      xfer_cnt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic          ack_s1;
    logic          ack_s2;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_inc;
    logic          accept;
    logic          complete;
    logic          timeout_set;
    logic          proto_set;

    assign src_ready = rst_n && (state == IDLE);

    // saturating next value of the wait counter
    assign wait_inc = (wait_cnt == TLIM) ? wait_cnt : wait_cnt + CW'(1);

    assign timeout_set = TO_EN && (state == WAIT) && (wait_inc == TLIM);
    assign proto_set   = (state == IDLE) && (ack_s2 != xfer_req);

    // two-flop synchroniser for the asynchronous acknowledge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= xfer_ack;
            ack_s2 <= ack_s1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state: accept in IDLE, complete when the ack matches the request
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        unique case (state)
            IDLE: begin
                if (src_valid && src_ready) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (ack_s2 == xfer_req) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // request/payload launch and wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_req  <= 1'b0;
            xfer_data <= '0;
            wait_cnt  <= '0;
        end else if (accept) begin
            xfer_req  <= ~xfer_req;
            xfer_data <= src_data;
            wait_cnt  <= '0;
        end else if (state == WAIT) begin
            wait_cnt  <= wait_inc;
        end
    end

    // completed-transfer counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (complete) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    // sticky error flags; a new error wins over a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            timeout_err <= timeout_set || (timeout_err && !err_clr);
            proto_err   <= proto_set || (proto_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed and randomized handshake checks against a
// transaction-level model of request parity, payload and transfer count.
module tb_cdc_hs_tx;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         src_valid;
    logic         src_ready;
    logic [W-1:0] src_data;
    logic         xfer_req;
    logic [W-1:0] xfer_data;
    logic         xfer_ack;
    logic         err_clr;
    logic         timeout_err;
    logic         proto_err;
    logic [15:0]  xfer_cnt;

    int total = 0;
    int bad   = 0;

    bit           m_req;
    int           m_cnt;
    logic [W-1:0] m_data;

    cdc_hs_tx #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .xfer_ack   (xfer_ack),
        .err_clr    (err_clr),
        .timeout_err(timeout_err),
        .proto_err  (proto_err),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one complete transfer; ack arrives dly cycles after the accept
    task automatic xfer(input logic [W-1:0] d, input int dly,
                        input bit hold, input logic [W-1:0] nxt);
        src_valid = 1'b1;
        src_data  = d;
        chk("rdy_pre", 32'(src_ready), 32'd1);
        tick;
        m_req  = ~m_req;
        m_data = d;
        if (hold) begin
            src_data = nxt;
        end else begin
            src_valid = 1'b0;
            src_data  = W'($urandom);
        end
        chk("req", 32'(xfer_req), 32'(m_req));
        chk("data", 32'(xfer_data), 32'(m_data));
        chk("rdy_busy", 32'(src_ready), 32'd0);
        for (int i = 0; i < dly; i++) begin
            tick;
            chk("req_hold", 32'(xfer_req), 32'(m_req));
            chk("data_hold", 32'(xfer_data), 32'(m_data));
            chk("rdy_wait", 32'(src_ready), 32'd0);
        end
        xfer_ack = m_req;
        tick;
        chk("rdy_m0", 32'(src_ready), 32'd0);
        tick;
        chk("rdy_m1", 32'(src_ready), 32'd0);
        tick;
        chk("rdy_m2", 32'(src_ready), 32'd1);
        m_cnt = (m_cnt + 1) % 65536;
        chk("cnt", 32'(xfer_cnt), 32'(m_cnt));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(src_ready), 32'd0);
        chk({tag, "_req"}, 32'(xfer_req), 32'd0);
        chk({tag, "_data"}, 32'(xfer_data), 32'd0);
        chk({tag, "_cnt"}, 32'(xfer_cnt), 32'd0);
        chk({tag, "_to"}, 32'(timeout_err), 32'd0);
        chk({tag, "_pe"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        logic [W-1:0] w [4];
        rst_n     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        xfer_ack  = 1'b0;
        err_clr   = 1'b0;
        m_req     = 1'b0;
        m_cnt     = 0;
        tick;
        tick;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        #1;
        chk("rdy_rel", 32'(src_ready), 32'd1);

        // single transfer of 8'hA5
        xfer(8'hA5, 4, 1'b0, 8'h00);
        chk("single_req", 32'(xfer_req), 32'd1);
        chk("single_cnt", 32'(xfer_cnt), 32'd1);

        // back-to-back with valid held, round trip of 4 cycles
        for (int i = 0; i < 4; i++) w[i] = W'($urandom);
        for (int i = 0; i < 4; i++) begin
            xfer(w[i], 3, 1'b1, (i < 3) ? w[(i + 1) % 4] : W'($urandom));
        end
        src_valid = 1'b0;
        chk("b2b_cnt", 32'(xfer_cnt), 32'd5);

        // timeout: no ack for 16+ wait cycles, late ack still completes
        src_valid = 1'b1;
        src_data  = 8'h3C;
        tick;
        src_valid = 1'b0;
        m_req     = ~m_req;
        chk("to_req", 32'(xfer_req), 32'(m_req));
        repeat (15) tick;
        chk("to_early", 32'(timeout_err), 32'd0);
        tick;
        chk("to_set", 32'(timeout_err), 32'd1);
        repeat (4) tick;
        chk("to_hold_req", 32'(xfer_req), 32'(m_req));
        chk("to_hold_data", 32'(xfer_data), 32'h3C);
        chk("to_hold_rdy", 32'(src_ready), 32'd0);
        xfer_ack = m_req;
        repeat (3) tick;
        chk("to_done_rdy", 32'(src_ready), 32'd1);
        m_cnt = (m_cnt + 1) % 65536;
        chk("to_cnt", 32'(xfer_cnt), 32'(m_cnt));
        chk("to_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("to_clr", 32'(timeout_err), 32'd0);

        // spurious ack while idle
        xfer_ack = ~m_req;
        tick;
        chk("pe_m0", 32'(proto_err), 32'd0);
        tick;
        chk("pe_m1", 32'(proto_err), 32'd0);
        tick;
        chk("pe_m2", 32'(proto_err), 32'd1);
        chk("pe_rdy", 32'(src_ready), 32'd1);
        err_clr = 1'b1;
        tick;
        chk("pe_setwins", 32'(proto_err), 32'd1);
        xfer_ack = m_req;
        tick;
        chk("pe_r0", 32'(proto_err), 32'd1);
        tick;
        chk("pe_r1", 32'(proto_err), 32'd1);
        tick;
        chk("pe_clr", 32'(proto_err), 32'd0);
        err_clr = 1'b0;
        xfer(W'($urandom), 2, 1'b0, 8'h00);

        // reset in the middle of WAIT
        src_valid = 1'b1;
        src_data  = 8'h77;
        tick;
        src_valid = 1'b0;
        tick;
        tick;
        rst_n    = 1'b0;
        xfer_ack = 1'b0;
        tick;
        chk_reset_vals("mid");
        m_req = 1'b0;
        m_cnt = 0;
        rst_n = 1'b1;
        #1;
        chk("mid_rdy", 32'(src_ready), 32'd1);
        tick;
        chk("mid_pe", 32'(proto_err), 32'd0);

        // randomized transfers
        for (int i = 0; i < 12; i++) begin
            xfer(W'($urandom), int'($urandom_range(0, 6)),
                 1'($urandom), W'($urandom));
        end
        src_valid = 1'b0;
        tick;

        // wrap of the transfer counter from a preloaded value
        force dut.xfer_cnt = 16'hFFFE;
        #1;
        release dut.xfer_cnt;
        m_cnt = 65534;
        for (int i = 0; i < 3; i++) begin
            xfer(W'($urandom), int'($urandom_range(0, 4)), 1'b0, 8'h00);
        end
        chk("wrap_cnt", 32'(xfer_cnt), 32'd1);
        chk("wrap_to", 32'(timeout_err), 32'd0);
        chk("wrap_pe", 32'(proto_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
